// File: rtl/ps2_key_event.sv
//==============================================================================
// Module      : ps2_key_event
// Description : PS/2 keyboard receiver producing an 11-bit toggle-strobe key
//               event word. Synchronises and glitch-filters the PS/2 lines,
//               deserialises 11-bit frames (start, 8 data LSB first, odd
//               parity, stop), and folds E0/F0/E1 prefixes into one event
//               per key transition.
// Ports       : Clk_12_I    - 12 MHz system clock
//               Reset_I     - asynchronous active-low reset
//               ps2_clk_I   - raw PS/2 clock (asynchronous, idles high)
//               ps2_data_I  - raw PS/2 data (asynchronous, idles high)
//               ps2_key_O   - [10] event toggle, [9] make, [8] E0, [7:0] code
//               frame_err_O - one-cycle pulse on parity/stop/timeout error
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ps2_key_event #(
   parameter int FILT_LEN    = 4,
   parameter int TIMEOUT_CYC = 24000
) (
   input  logic        Clk_12_I,
   input  logic        Reset_I,
   input  logic        ps2_clk_I,
   input  logic        ps2_data_I,
   output logic [10:0] ps2_key_O,
   output logic        frame_err_O
);

   localparam int c_FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam int c_TCNT_W = $clog2(TIMEOUT_CYC + 1);

   localparam logic [c_FCNT_W-1:0] c_FCNT_LAST = c_FCNT_W'(FILT_LEN - 1);
   localparam logic [c_TCNT_W-1:0] c_TCNT_LAST = c_TCNT_W'(TIMEOUT_CYC - 1);
   localparam logic [c_TCNT_W-1:0] c_TCNT_MAX  = c_TCNT_W'(TIMEOUT_CYC);

   //---------------------------------------------------------------------------
   // Two-flop synchronisers; both lines idle high so they reset to 1.
   //---------------------------------------------------------------------------
   logic r_clk_meta;
   logic r_clk_sync;
   logic r_dat_meta;
   logic r_dat_sync;

   always_ff @(posedge Clk_12_I or negedge Reset_I) begin
      if (!Reset_I) begin
         r_clk_meta <= 1'b1;
         r_clk_sync <= 1'b1;
         r_dat_meta <= 1'b1;
         r_dat_sync <= 1'b1;
      end else begin
         r_clk_meta <= ps2_clk_I;
         r_clk_sync <= r_clk_meta;
         r_dat_meta <= ps2_data_I;
         r_dat_sync <= r_dat_meta;
      end
   end

   //---------------------------------------------------------------------------
   // Clock glitch filter: the filtered level follows the synchronised level
   // only after FILT_LEN consecutive samples that differ from it. Any sample
   // that agrees with the current filtered level restarts the count.
   //---------------------------------------------------------------------------
   logic [c_FCNT_W-1:0] r_fcnt;
   logic                r_clk_filt;
   logic                r_clk_filt_d;
   logic                w_fall;

   always_ff @(posedge Clk_12_I or negedge Reset_I) begin
      if (!Reset_I) begin
         r_fcnt       <= '0;
         r_clk_filt   <= 1'b1;
         r_clk_filt_d <= 1'b1;
      end else begin
         r_clk_filt_d <= r_clk_filt;
         if (r_clk_sync == r_clk_filt) begin
            r_fcnt <= '0;
         end else if (r_fcnt == c_FCNT_LAST) begin
            r_clk_filt <= r_clk_sync;
            r_fcnt     <= '0;
         end else begin
            r_fcnt <= r_fcnt + 1'b1;
         end
      end
   end

   // Falling edge of the filtered clock; consumed on the following edge,
   // which is the bit-sampling point.
   assign w_fall = r_clk_filt_d & ~r_clk_filt;

   //---------------------------------------------------------------------------
   // Frame FSM with timeout. Produces a registered one-cycle byte strobe or
   // error request; the decoder stage below turns these into outputs.
   //---------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   state_t              r_state;
   logic [2:0]          r_bit_cnt;
   logic [7:0]          r_shift;
   logic                r_par_ok;
   logic [c_TCNT_W-1:0] r_tcnt;
   logic                r_byte_vld;
   logic [7:0]          r_byte;
   logic                r_err_req;

   always_ff @(posedge Clk_12_I or negedge Reset_I) begin
      if (!Reset_I) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= 3'd0;
         r_shift    <= 8'h00;
         r_par_ok   <= 1'b0;
         r_tcnt     <= '0;
         r_byte_vld <= 1'b0;
         r_byte     <= 8'h00;
         r_err_req  <= 1'b0;
      end else begin
         r_byte_vld <= 1'b0;
         r_err_req  <= 1'b0;

         if (w_fall) begin
            // A bit edge always beats a coincident timeout.
            r_tcnt <= '0;
            case (r_state)
               ST_IDLE: begin
                  if (!r_dat_sync) begin
                     r_state   <= ST_DATA;
                     r_bit_cnt <= 3'd0;
                  end
               end
               ST_DATA: begin
                  r_shift   <= {r_dat_sync, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= ST_PARITY;
                  end
               end
               ST_PARITY: begin
                  // Odd parity: data plus parity bit must hold an odd
                  // number of ones.
                  r_par_ok <= ^{r_shift, r_dat_sync};
                  r_state  <= ST_STOP;
               end
               ST_STOP: begin
                  r_state <= ST_IDLE;
                  if (r_dat_sync && r_par_ok) begin
                     r_byte_vld <= 1'b1;
                     r_byte     <= r_shift;
                  end else begin
                     r_err_req <= 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end else if (r_state == ST_IDLE) begin
            r_tcnt <= '0;
         end else if (r_tcnt == c_TCNT_LAST) begin
            // Counter reaches TIMEOUT_CYC on this edge: abort the frame and
            // hold at the limit rather than wrapping.
            r_state   <= ST_IDLE;
            r_err_req <= 1'b1;
            r_tcnt    <= c_TCNT_MAX;
         end else if (r_tcnt != c_TCNT_MAX) begin
            r_tcnt <= r_tcnt + 1'b1;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Byte decoder: folds prefixes into a single event word per key change.
   //---------------------------------------------------------------------------
   logic       r_ext;
   logic       r_brk;
   logic [2:0] r_skip;

   always_ff @(posedge Clk_12_I or negedge Reset_I) begin
      if (!Reset_I) begin
         ps2_key_O   <= 11'h000;
         frame_err_O <= 1'b0;
         r_ext       <= 1'b0;
         r_brk       <= 1'b0;
         r_skip      <= 3'd0;
      end else begin
         frame_err_O <= r_err_req;

         if (r_err_req) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_skip <= 3'd0;
         end else if (r_byte_vld) begin
            if (r_skip != 3'd0) begin
               // Remainder of the E1 (Pause) sequence is swallowed whole.
               r_skip <= r_skip - 3'd1;
            end else begin
               case (r_byte)
                  8'hE0: r_ext <= 1'b1;
                  8'hF0: r_brk <= 1'b1;
                  8'hE1: begin
                     r_skip <= 3'd7;
                     r_ext  <= 1'b0;
                     r_brk  <= 1'b0;
                  end
                  // Acknowledge, self-test, echo, resend and overrun codes
                  // are not key events.
                  8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                     r_ext <= 1'b0;
                     r_brk <= 1'b0;
                  end
                  default: begin
                     ps2_key_O <= {~ps2_key_O[10], ~r_brk, r_ext, r_byte};
                     r_ext     <= 1'b0;
                     r_brk     <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_event.sv
//==============================================================================
// Module      : tb_ps2_key_event
// Description : Self-checking bench for ps2_key_event. Drives PS/2 frames,
//               predicts key events with a byte-level model and checks them
//               through a scoreboard queue drained by an output monitor.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_key_event;

   localparam int FILT_LEN    = 4;
   localparam int TIMEOUT_CYC = 24000;
   // Cycles from the negedge that drives a PS/2 clock fall to the negedge
   // at which the resulting output change is first visible.
   localparam int LAT         = FILT_LEN + 4;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        ps2_clk  = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] key;
   logic        ferr;

   ps2_key_event #(
      .FILT_LEN    (FILT_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .Clk_12_I    (clk),
      .Reset_I     (rst_n),
      .ps2_clk_I   (ps2_clk),
      .ps2_data_I  (ps2_data),
      .ps2_key_O   (key),
      .frame_err_O (ferr)
   );

   always #42 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_err;
      logic [10:0] key;
      int          lo;
      int          hi;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 0;

   // Reference model state: last event toggle and pending prefix flags.
   bit   m_tog  = 0;
   bit   m_ext  = 0;
   bit   m_brk  = 0;
   int   m_skip = 0;

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_clear();
      m_ext = 0;
      m_brk = 0;
   endtask

   task automatic model_err(input int lo, input int hi);
      exp_t e;
      e.is_err = 1; e.key = 11'h000; e.lo = lo; e.hi = hi;
      sbq.push_back(e);
      model_clear();
      m_skip = 0;
   endtask

   task automatic model_byte(input logic [7:0] b, input int fall_cyc);
      exp_t e;
      if (m_skip > 0) begin
         m_skip--;
      end else begin
         case (b)
            8'hE0: m_ext = 1;
            8'hF0: m_brk = 1;
            8'hE1: begin m_skip = 7; model_clear(); end
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: model_clear();
            default: begin
               m_tog    = ~m_tog;
               e.is_err = 0;
               e.key    = {m_tog, ~m_brk, m_ext, b};
               e.lo     = fall_cyc + LAT;
               e.hi     = fall_cyc + LAT;
               sbq.push_back(e);
               model_clear();
            end
         endcase
      end
   endtask

   task automatic check_event(input bit is_err, input logic [10:0] k);
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got err=%0b key=%h at cyc %0d, required no event",
                  is_err, k, cyc);
         return;
      end
      e = sbq.pop_front();
      if (e.is_err != is_err || (!is_err && e.key !== k) || cyc < e.lo || cyc > e.hi) begin
         errors++;
         $display("FAIL event: got err=%0b key=%h cyc=%0d, required err=%0b key=%h cyc=%0d..%0d",
                  is_err, k, cyc, e.is_err, e.key, e.lo, e.hi);
      end
   endtask

   // Output monitor: every error pulse cycle and every change of the key
   // word consumes one scoreboard entry.
   initial begin : monitor
      logic [10:0] prev_key;
      prev_key = 11'h000;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (ferr === 1'b1) check_event(1'b1, key);
            if (key !== prev_key) check_event(1'b0, key);
         end
         prev_key = key;
      end
   end

   task automatic ps2_bit(input logic v, input int half, output int fall_cyc);
      ps2_data = v;
      wait_cyc(half);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      wait_cyc(half);
      ps2_clk  = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int half);
      logic [9:0] bits;
      int         fc;
      bits = {(~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 10; i++) ps2_bit(bits[i], half, fc);
      // Stop bit: the expectation is queued at the fall, before it can show.
      ps2_data = ~bad_stop;
      wait_cyc(half);
      ps2_clk = 1'b0;
      fc      = cyc;
      if (bad_par || bad_stop) model_err(fc + LAT, fc + LAT);
      else                     model_byte(b, fc);
      wait_cyc(half);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_cyc(2 * half);
   endtask

   task automatic send_seq(input logic [7:0] s[$]);
      foreach (s[i]) send_frame(s[i], 1'b0, 1'b0, 20);
   endtask

   initial begin : stim
      int          fc;
      logic [7:0]  b;
      int          sel;
      bit          bad;
      logic [7:0]  fa_list[6];

      fa_list = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

      // Reset state.
      wait_cyc(5);
      checks++;
      if (key !== 11'h000 || ferr !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got key=%h err=%0b, required key=000 err=0", key, ferr);
      end
      rst_n = 1'b1;
      wait_cyc(5);
      mon_en = 1;

      // Make 0x29 at a 12.5 kHz PS/2 clock (960 cycles per bit).
      send_frame(8'h29, 1'b0, 1'b0, 480);
      // Break 0x29, then extended make/break of 0x75.
      send_seq('{8'hF0, 8'h29});
      send_seq('{8'hE0, 8'h75});
      send_seq('{8'hE0, 8'hF0, 8'h75});

      // Parity error then a good byte; pending prefix also discarded.
      send_frame(8'h29, 1'b1, 1'b0, 20);
      send_seq('{8'h16});
      send_seq('{8'hF0});
      send_frame(8'h33, 1'b0, 1'b1, 20);
      send_seq('{8'h34});

      // Partial frame (start + 5 bits) then idle until timeout.
      ps2_bit(1'b0, 20, fc);
      for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)), 20, fc);
      ps2_data = 1'b1;
      model_err(fc + TIMEOUT_CYC, fc + TIMEOUT_CYC + 12);
      wait_cyc(TIMEOUT_CYC + 60);
      send_seq('{8'h1E});

      // Short low glitch on the clock with data low: must not start a frame.
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      wait_cyc(3);
      ps2_clk  = 1'b1;
      wait_cyc(20);
      ps2_data = 1'b1;
      wait_cyc(20);
      send_seq('{8'h1C});

      // Non-key codes and the Pause sequence produce nothing.
      send_seq('{8'hFA});
      send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
      send_seq('{8'h16});

      // Randomised traffic.
      for (int n = 0; n < 30; n++) begin
         sel = int'($urandom_range(0, 11));
         case (sel)
            0:       b = 8'hE0;
            1, 2:    b = 8'hF0;
            3:       b = 8'hE1;
            4:       b = fa_list[$urandom_range(0, 5)];
            default: b = 8'($urandom_range(0, 255));
         endcase
         bad = (m_skip == 0) && ($urandom_range(0, 9) == 0);
         send_frame(b, bad, 1'b0, 20);
      end

      // Reset in the middle of a frame: no event, no error, clean restart.
      wait_cyc(40);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL pending_before_reset: got %0d queued, required 0", sbq.size());
      end
      ps2_bit(1'b0, 20, fc);
      for (int i = 0; i < 3; i++) ps2_bit(1'b1, 20, fc);
      mon_en = 0;
      rst_n  = 1'b0;
      wait_cyc(3);
      rst_n  = 1'b1;
      wait_cyc(5);
      checks++;
      if (key !== 11'h000 || ferr !== 1'b0) begin
         errors++;
         $display("FAIL midframe_reset: got key=%h err=%0b, required key=000 err=0", key, ferr);
      end
      m_tog  = 0;
      m_skip = 0;
      model_clear();
      mon_en = 1;
      send_seq('{8'hE0, 8'h1C});

      wait_cyc(200);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL missing_events: got %0d events never seen, required 0", sbq.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ps2_key_event.md
# ps2_key_event

Converts the raw PS/2 keyboard line pair into the 11-bit toggle-strobe key-event word consumed by the core's keyboard decoders (bit 10 toggle, bit 9 pressed, bits 8:0 code). It sits between the board-level PS/2 pins and the `ps2_key` consumers, and lets a core run standalone without the HPS keyboard path. It deserialises frames, checks parity and framing, and folds the E0/F0/E1 prefix sequences into one event per key transition.

## Interface
Parameters:
- FILT_LEN, 4: consecutive identical samples required before the filtered PS/2 clock changes level.
- TIMEOUT_CYC, 24000: idle cycles (2 ms at 12 MHz) after which a partial frame is aborted.

Ports:
- Clk_12_I  in  1  system clock, 12 MHz.
- Reset_I  in  1  asynchronous, active-low reset.
- ps2_clk_I  in  1  raw PS/2 clock; asynchronous; idles high.
- ps2_data_I  in  1  raw PS/2 data; asynchronous; idles high.
- ps2_key_O  out  11  [10] toggles once per event, [9] 1=make/0=break, [8] E0-extended, [7:0] scancode.
- frame_err_O  out  1  one-cycle pulse on parity, stop-bit or timeout error.

## Operation
- Synchroniser: two flops on each line.
- Glitch filter: the filtered clock takes the synchronised level after FILT_LEN equal consecutive samples. Data is only synchronised.
- A falling edge of the filtered clock samples data.
- Frame FSM states: IDLE, DATA, PARITY, STOP. The bit counter runs 0..7 in DATA, LSB first.
  - IDLE: a sampled 0 (start bit) moves to DATA. A sampled 1 is ignored and the FSM stays in IDLE.
  - DATA: after 8 bits, move to PARITY.
  - PARITY: compare against odd parity over the 8 data bits plus the parity bit.
  - STOP: the stop bit must be 1. Either way, return to IDLE.
- Error: a parity mismatch or stop=0 discards the byte, pulses frame_err_O and clears all prefix flags.
- Timeout: a counter is cleared on every filtered falling edge. In any state other than IDLE, reaching TIMEOUT_CYC aborts to IDLE, pulses frame_err_O and clears the prefix flags.
- Byte decoder (good frames only):
  - E0 sets ext.
  - F0 sets brk.
  - E1 loads skip=7. The next 7 good bytes are dropped and the flags are left clear.
  - FA, AA, EE, FE, 00, FF are dropped and the flags are cleared.
  - Any other byte b: ps2_key_O <= {~ps2_key_O[10], ~brk, ext, b}; ext and brk are cleared.
- Reset: ps2_key_O=0, frame_err_O=0, FSM=IDLE, ext=brk=0, skip=0, timeout=0. Synchroniser and filter outputs reset to 1.
- Reset asserted mid-frame drops the frame with no event and no error pulse.

## Timing
- Let k be the first Clk_12_I edge sampling raw ps2_clk_I low for the stop bit (line stable):
  - the filtered falling edge is detected at edge k+2+FILT_LEN;
  - ps2_key_O, or frame_err_O, updates at edge k+3+FILT_LEN (k+7 at default).
- Data is sampled from the synchronised ps2_data at the detect edge. PS/2 data is stable for at least 5 µs around the clock fall, so the fixed FILT_LEN lag is safe.
- At most one ps2_key_O change per stop bit. Consumers detect events by edge of bit 10 only; no strobe is provided.
- The timeout and a filtered falling edge can occur on the same cycle. The edge wins: the counter clears and the bit is taken.
- Timeout is inactive in IDLE. The counter saturates and never wraps.
- A timeout pulse and an error pulse can never coincide; each produces exactly one cycle.

## Test plan
- Reset, then frame 0x29 (parity bit 0, stop 1) at a 12.5 kHz PS/2 clock -> ps2_key_O=11'h629 exactly 7 cycles after the stop-bit fall; frame_err_O stays 0.
- Then F0, 29 -> one change only, ps2_key_O=11'h029. The F0 byte alone produces no change.
- Then E0 75 -> 11'h775; then E0 F0 75 -> 11'h175.
- Frame 0x29 with parity bit 1 -> frame_err_O high for exactly 1 cycle, ps2_key_O unchanged. A following good 0x16 -> {~t,1,0,16}.
- Start plus 5 bits, then the clock held high for 24000 cycles -> frame_err_O pulse on cycle 24000 after the last fall, FSM back to IDLE. A full frame 0x1E then decodes correctly.
- 3-cycle low glitch on ps2_clk_I (FILT_LEN=4) -> no bit taken. FA byte -> no change. E1 14 77 E1 F0 14 F0 77 -> no change, and the next 0x16 decodes as a make.
